// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with registered one-hot grant.
// An optional hold limit forces the owner to rotate when others wait.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  localparam bit         HOLD_EN  = (MAX_HOLD != 0);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [1:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic       preempt_q, preempt_d;
  logic [3:0] gnt_q, gnt_d;

  // First set bit of r scanning s, s+1, s+2, s+3 (mod 4); bit 2 = found.
  function automatic logic [2:0] pick(
    input logic [3:0] r,
    input logic [1:0] s
  );
    logic [2:0] res;
    logic [1:0] k;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      k = s + 2'(i);
      if (r[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  logic [1:0] owner;
  logic [1:0] nxt_ptr;
  logic [2:0] idle_win;
  logic [2:0] rot_win;
  logic       own_req;
  logic       timeout;
  logic [7:0] hold_inc;

  always_comb begin
    owner    = idx_q;
    nxt_ptr  = owner + 2'd1;
    own_req  = req[owner];
    idle_win = pick(req, ptr_q);
    rot_win  = pick(req, nxt_ptr);
    timeout  = HOLD_EN && (hold_cnt_q >= HOLD_LIM);
    hold_inc = (hold_cnt_q == 8'hFF) ? hold_cnt_q
                                     : hold_cnt_q + 8'd1;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    preempt_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (idle_win[2]) begin
          state_d    = GRANT;
          idx_d      = idle_win[1:0];
          valid_d    = 1'b1;
          hold_cnt_d = 8'd1;
        end
      end
      GRANT: begin
        if (own_req && !timeout) begin
          hold_cnt_d = hold_inc;
        end else if (!own_req) begin
          ptr_d = nxt_ptr;
          if (rot_win[2]) begin
            idx_d      = rot_win[1:0];
            hold_cnt_d = 8'd1;
          end else begin
            state_d    = IDLE;
            valid_d    = 1'b0;
            hold_cnt_d = 8'd0;
          end
        end else begin
          // Timeout: owner sits last in the search, so it only wins alone.
          ptr_d      = nxt_ptr;
          idx_d      = rot_win[1:0];
          hold_cnt_d = 8'd1;
          preempt_d  = (rot_win[1:0] != owner);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    gnt_d = valid_d ? (4'b0001 << idx_d) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      hold_cnt_q <= 8'd0;
      idx_q      <= 2'd0;
      valid_q    <= 1'b0;
      preempt_q  <= 1'b0;
      gnt_q      <= 4'b0000;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      preempt_q  <= preempt_d;
      gnt_q      <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: per-cycle vector table plus
// hand sequences for hold-limit rotation.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int checks;
  int errors;

  rr_arbiter4 #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       pre;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] q,
                     input logic [3:0] g, input logic [1:0] i,
                     input logic v, input logic p);
    vec_t t;
    t.rst = r; t.req = q; t.gnt = g;
    t.idx = i; t.valid = v; t.pre = p;
    vecs.push_back(t);
  endtask

  task automatic step(input logic r, input logic [3:0] q);
    @(negedge clk);
    rst = r;
    req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [3:0] g,
                            input logic [1:0] i, input logic v,
                            input logic p);
    checks++;
    if (gnt !== g || gnt_valid !== v || preempt !== p ||
        (v && gnt_idx !== i)) begin
      errors++;
      $display("FAIL %s: got gnt=%b idx=%0d valid=%b pre=%b, want gnt=%b idx=%0d valid=%b pre=%b",
               name, gnt, gnt_idx, gnt_valid, preempt, g, i, v, p);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string nm;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    req = 4'b0000;

    // reset with all requests
    add(1, 4'b1111, 4'b0000, 0, 0, 0);
    add(1, 4'b1111, 4'b0000, 0, 0, 0);
    // single request, release, then ptr=3 shows up in next pick
    add(0, 4'b0100, 4'b0100, 2, 1, 0);
    add(0, 4'b0100, 4'b0100, 2, 1, 0);
    add(0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b1111, 4'b1000, 3, 1, 0);
    // release-and-reraise rotation 0,1,2,3,0 with no gap
    add(1, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b1111, 4'b0001, 0, 1, 0);
    add(0, 4'b1110, 4'b0010, 1, 1, 0);
    add(0, 4'b1101, 4'b0100, 2, 1, 0);
    add(0, 4'b1011, 4'b1000, 3, 1, 0);
    add(0, 4'b0111, 4'b0001, 0, 1, 0);
    // reset mid-grant (owner 2, hold 5) with ptr previously 3
    add(1, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b0100, 4'b0100, 2, 1, 0);
    add(0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b0100, 4'b0100, 2, 1, 0);
    add(0, 4'b0100, 4'b0100, 2, 1, 0);
    add(0, 4'b0100, 4'b0100, 2, 1, 0);
    add(0, 4'b0100, 4'b0100, 2, 1, 0);
    add(0, 4'b0100, 4'b0100, 2, 1, 0);
    add(1, 4'b0100, 4'b0000, 0, 0, 0);
    add(0, 4'b1100, 4'b0100, 2, 1, 0);
    // non-owner request changes ignored mid-grant
    add(0, 4'b0100, 4'b0100, 2, 1, 0);
    add(0, 4'b0101, 4'b0100, 2, 1, 0);
    add(0, 4'b0001, 4'b0001, 0, 1, 0);

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].req);
      nm = $sformatf("vec%0d", k);
      expect_out(nm, vecs[k].gnt, vecs[k].idx,
                 vecs[k].valid, vecs[k].pre);
    end

    // hold limit of 8 with two constant requesters
    step(1, 4'b0000);
    expect_out("hold_rst", 4'b0000, 0, 0, 0);
    for (int c = 0; c < 8; c++) begin
      step(0, 4'b0011);
      expect_out($sformatf("hold_a0_%0d", c), 4'b0001, 0, 1, 0);
    end
    for (int c = 0; c < 8; c++) begin
      step(0, 4'b0011);
      expect_out($sformatf("hold_a1_%0d", c), 4'b0010, 1, 1,
                 (c == 0) ? 1'b1 : 1'b0);
    end
    step(0, 4'b0011);
    expect_out("hold_back_a0", 4'b0001, 0, 1, 1);
    step(0, 4'b0011);
    expect_out("hold_a0_again", 4'b0001, 0, 1, 0);

    // lone requester is re-granted at timeout without preempt
    step(1, 4'b0000);
    expect_out("lone_rst", 4'b0000, 0, 0, 0);
    for (int c = 0; c < 20; c++) begin
      step(0, 4'b1000);
      expect_out($sformatf("lone_a3_%0d", c), 4'b1000, 3, 1, 0);
    end

    // timeout picks from owner+1 even when a lower index waits
    step(1, 4'b0000);
    step(0, 4'b0010);
    expect_out("to_a1_first", 4'b0010, 1, 1, 0);
    for (int c = 0; c < 7; c++) begin
      step(0, 4'b1011);
      expect_out($sformatf("to_a1_%0d", c), 4'b0010, 1, 1, 0);
    end
    step(0, 4'b1011);
    expect_out("to_a3_win", 4'b1000, 3, 1, 1);
    step(0, 4'b0000);
    expect_out("to_idle", 4'b0000, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
